// File: rtl/tick_rate_controller.sv
// ----------------------------------------------------------------------------
// tick_rate_controller
//
// Programmable prescaler sequencer for the fabric clock. The block can be
// started and stopped, run continuously or for a fixed number of ticks, and
// accept a new divisor at any time. A divisor that arrives while running is
// held back and only takes effect at the next period boundary, so consumers
// never see a truncated or stretched period.
//
// Parameters
//   CNT_W        width of divisor and period counter
//   DEFAULT_DIV  divisor after reset (period = div+1 cycles)
//   MIN_DIV      smallest legal divisor; smaller requests are clamped up
//   BURST_W      width of burst length / tick counter
//
// Ports
//   clk_in     in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   level, accepted in IDLE only
//   stop       in   level, accepted in RUN, wins over start
//   burst_len  in   ticks per run (0 = continuous), latched on start
//   cfg_valid  in   divisor update request
//   cfg_div    in   requested divisor
//   cfg_ready  out  combinational; update transfers on cfg_valid && cfg_ready
//   tick       out  one-cycle enable per period
//   clk_out    out  square wave toggling on every tick
//   busy       out  high while running
//   done       out  one-cycle pulse when a burst completes
//   cur_div    out  divisor currently in effect
// ----------------------------------------------------------------------------
module tick_rate_controller #(
   parameter int          CNT_W       = 32,
   parameter int unsigned DEFAULT_DIV = 25000000,
   parameter int unsigned MIN_DIV     = 1,
   parameter int          BURST_W     = 16
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               cfg_valid,
   input  logic [CNT_W-1:0]   cfg_div,
   output logic               cfg_ready,
   output logic               tick,
   output logic               clk_out,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   cur_div
);

   localparam logic [CNT_W-1:0] LP_MIN_DIV = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] LP_RST_DIV = (DEFAULT_DIV > MIN_DIV) ? CNT_W'(DEFAULT_DIV)
                                                                      : CNT_W'(MIN_DIV);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [BURST_W-1:0] r_tick_cnt, w_tick_cnt_nxt;
   logic [BURST_W-1:0] r_burst, w_burst_nxt;
   logic               r_tick, w_tick_nxt;
   logic               r_clk_out, w_clk_out_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_pend_valid, w_pend_valid_nxt;
   logic [CNT_W-1:0]   r_pend_div, w_pend_div_nxt;
   logic [CNT_W-1:0]   r_cur_div, w_cur_div_nxt;

   logic               w_cfg_xfer;
   logic               w_wrap;
   logic               w_last;
   logic [BURST_W-1:0] w_tick_cnt_sat;

   function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
      return (d < LP_MIN_DIV) ? LP_MIN_DIV : d;
   endfunction

   // Ready drops while a pending divisor waits, so a new request can never
   // collide with the application of the old one.
   assign cfg_ready  = !r_pend_valid && !rst;
   assign w_cfg_xfer = cfg_valid && cfg_ready;

   // Unsigned >= keeps the period bounded even if cur_div shrinks mid-count.
   assign w_wrap = (r_cnt >= r_cur_div);

   // Extra bit so tick_cnt+1 cannot alias to zero when comparing to burst.
   assign w_last = (r_burst != '0) &&
                   (({1'b0, r_tick_cnt} + (BURST_W+1)'(1)) == {1'b0, r_burst});

   assign w_tick_cnt_sat = (&r_tick_cnt) ? r_tick_cnt : r_tick_cnt + BURST_W'(1);

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_tick_cnt_nxt   = r_tick_cnt;
      w_burst_nxt      = r_burst;
      w_tick_nxt       = 1'b0;
      w_clk_out_nxt    = r_clk_out;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_pend_valid_nxt = r_pend_valid;
      w_pend_div_nxt   = r_pend_div;
      w_cur_div_nxt    = r_cur_div;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt     = '0;
            w_clk_out_nxt = 1'b0;
            w_busy_nxt    = 1'b0;
            // A divisor captured on the burst-end edge lands here.
            if (r_pend_valid) begin
               w_cur_div_nxt    = r_pend_div;
               w_pend_valid_nxt = 1'b0;
            end else if (w_cfg_xfer) begin
               w_cur_div_nxt = clamp_div(cfg_div);
            end
            if (start && !stop) begin
               w_state_nxt    = S_RUN;
               w_tick_cnt_nxt = '0;
               w_burst_nxt    = burst_len;
               w_busy_nxt     = 1'b1;
            end
         end

         S_RUN: begin
            if (stop) begin
               // Stop suppresses any tick/done this edge would have produced.
               w_state_nxt   = S_IDLE;
               w_cnt_nxt     = '0;
               w_clk_out_nxt = 1'b0;
               w_busy_nxt    = 1'b0;
               if (r_pend_valid) begin
                  w_cur_div_nxt    = r_pend_div;
                  w_pend_valid_nxt = 1'b0;
               end else if (w_cfg_xfer) begin
                  w_cur_div_nxt = clamp_div(cfg_div);
               end
            end else if (w_wrap) begin
               w_cnt_nxt      = '0;
               w_tick_nxt     = 1'b1;
               w_tick_cnt_nxt = w_tick_cnt_sat;
               if (r_pend_valid) begin
                  w_cur_div_nxt    = r_pend_div;
                  w_pend_valid_nxt = 1'b0;
               end else if (w_cfg_xfer) begin
                  w_pend_div_nxt   = clamp_div(cfg_div);
                  w_pend_valid_nxt = 1'b1;
               end
               if (w_last) begin
                  w_done_nxt    = 1'b1;
                  w_state_nxt   = S_IDLE;
                  w_busy_nxt    = 1'b0;
                  w_clk_out_nxt = 1'b0;
               end else begin
                  w_clk_out_nxt = ~r_clk_out;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if (w_cfg_xfer) begin
                  w_pend_div_nxt   = clamp_div(cfg_div);
                  w_pend_valid_nxt = 1'b1;
               end
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_tick_cnt   <= '0;
         r_tick       <= 1'b0;
         r_clk_out    <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pend_valid <= 1'b0;
         r_cur_div    <= LP_RST_DIV;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_tick_cnt   <= w_tick_cnt_nxt;
         r_tick       <= w_tick_nxt;
         r_clk_out    <= w_clk_out_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_cur_div    <= w_cur_div_nxt;
      end
   end

   // Payload registers are only meaningful when qualified by state/pend_valid.
   always_ff @(posedge clk_in) begin
      r_burst    <= w_burst_nxt;
      r_pend_div <= w_pend_div_nxt;
   end

   assign tick    = r_tick;
   assign clk_out = r_clk_out;
   assign busy    = r_busy;
   assign done    = r_done;
   assign cur_div = r_cur_div;

endmodule
